fir_ap_ctrl: RTL and testbench

Block-level sequencer for the FIR engine. It owns the ap_start/ap_done/ap_idle protocol and the data_length register, and counts input and output stream handshakes to frame a run and generate sm_tlast. It also arbitrates the single tap-BRAM port between AXI-lite accesses and the engine. It sits between the AXI-lite write FIFO pop logic and the FIR datapath, replacing the ad-hoc status logic inside fir.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_tap_arb.sv | 25 ++
 rtl/fir_ap_ctrl.sv | 153 +++++++++++++++
 tb/tb_fir_ap_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR block.
//   - config register address map (AP control, data_length, tap window)
//   - bit positions of the status word read back at 0x00
//   - sequencer state type and tap-port request/grant bundles
package fir_pkg;

  localparam logic [11:0] ADDR_AP_CTRL = 12'h000;
  localparam logic [11:0] ADDR_DLEN_LO = 12'h010;
  localparam logic [11:0] ADDR_DLEN_HI = 12'h014;
  localparam logic [11:0] ADDR_TAP_LO  = 12'h020;
  localparam logic [11:0] ADDR_TAP_HI  = 12'h0FF;

  localparam int STAT_START_BIT = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

  typedef struct packed {
    logic eng;
    logic lite_rd;
    logic lite_wr;
  } tap_req_t;

  typedef struct packed {
    logic eng;
    logic lite;
  } tap_gnt_t;

endpackage

// File: rtl/fir_tap_arb.sv
// fir_tap_arb: zero-latency arbiter for the single tap-BRAM port.
//   idle  in  block is in IDLE (AXI-lite owns the port outright)
//   req   in  engine / AXI-lite read / AXI-lite write requests
//   gnt   out engine / AXI-lite grants, never both high
// While a run is active the engine has priority and lite writes are held
// off entirely so coefficients cannot change under a running filter.
module fir_tap_arb
  import fir_pkg::*;
(
  input  logic     idle,
  input  tap_req_t req,
  output tap_gnt_t gnt
);

  always_comb begin
    gnt = '0;
    if (idle) begin
      gnt.lite = req.lite_rd | req.lite_wr;
    end else begin
      gnt.eng  = req.eng;
      gnt.lite = req.lite_rd & ~req.eng;
    end
  end

endmodule

// File: rtl/fir_ap_ctrl.sv
// fir_ap_ctrl: block-level sequencer for the FIR engine.
//   cfg_wr/cfg_wdata   popped write to 0x00 (bit0 requests ap_start)
//   len_wr/len_wdata   popped write to data_length
//   stat_rd            accepted read of 0x00, clears ap_done
//   in_hs/out_hs       input/output stream handshakes
//   *_tap_req/_gnt     tap-BRAM port arbitration (see fir_tap_arb)
//   ap_start/done/idle status bits; data_length register
//   ss_gate            engine may accept input samples
//   sm_tlast           current output beat is the last of the run
//   proto_err          sticky: output handshake seen outside RUN/DRAIN
module fir_ap_ctrl
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int LEN_WIDTH   = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_wr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  input  logic                   len_wr,
  input  logic [LEN_WIDTH-1:0]   len_wdata,
  input  logic                   stat_rd,
  input  logic                   in_hs,
  input  logic                   out_hs,
  input  logic                   eng_tap_req,
  input  logic                   lite_tap_rd_req,
  input  logic                   lite_tap_wr_req,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic [LEN_WIDTH-1:0]   data_length,
  output logic                   ss_gate,
  output logic                   sm_tlast,
  output logic                   eng_tap_gnt,
  output logic                   lite_tap_gnt,
  output logic                   proto_err
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  fir_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 idle_q, idle_d;
  logic                 perr_q, perr_d;
  logic                 run_or_drain;

  // Only bit0 of the control word is meaningful here.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_wdata[pDATA_WIDTH-1:1];

  assign run_or_drain = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    len_d     = len_q;
    start_d   = start_q;
    idle_d    = idle_q;
    // Clear-on-read first so a completion in the same cycle overrides it.
    done_d    = done_q & ~stat_rd;
    perr_d    = perr_q | (out_hs & ~run_or_drain);

    case (state_q)
      ST_IDLE: begin
        if (len_wr) len_d = len_wdata;
        // Start qualification uses the length already in the register.
        if (cfg_wr && cfg_wdata[0] && (len_q != '0)) begin
          start_d   = 1'b1;
          idle_d    = 1'b0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (in_hs) begin
          start_d  = 1'b0;
          in_cnt_d = ONE;
          state_d  = (len_q == ONE) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_q + ONE;
          if (in_cnt_d == len_q) state_d = ST_DRAIN;
        end
      end
      default: ;
    endcase

    // Output counting is only meaningful once input has started flowing;
    // completion overrides any RUN->DRAIN decision made above.
    if (out_hs && run_or_drain) begin
      out_cnt_d = out_cnt_q + ONE;
      if (out_cnt_d == len_q) begin
        done_d  = 1'b1;
        idle_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      len_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      idle_q    <= 1'b1;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      len_q     <= len_d;
      start_q   <= start_d;
      done_q    <= done_d;
      idle_q    <= idle_d;
      perr_q    <= perr_d;
    end
  end

  assign ap_start    = start_q;
  assign ap_done     = done_q;
  assign ap_idle     = idle_q;
  assign data_length = len_q;
  assign proto_err   = perr_q;
  assign ss_gate     = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign sm_tlast    = run_or_drain && (out_cnt_q == len_q - ONE);

  tap_req_t tap_req;
  tap_gnt_t tap_gnt;

  assign tap_req = '{eng: eng_tap_req, lite_rd: lite_tap_rd_req, lite_wr: lite_tap_wr_req};

  fir_tap_arb u_tap_arb (
    .idle (state_q == ST_IDLE),
    .req  (tap_req),
    .gnt  (tap_gnt)
  );

  assign eng_tap_gnt  = tap_gnt.eng;
  assign lite_tap_gnt = tap_gnt.lite;

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// tb_fir_ap_ctrl: directed, table-driven check of the FIR sequencer.
module tb_fir_ap_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        cfg_wr;
  logic [31:0] cfg_wdata;
  logic        len_wr;
  logic [31:0] len_wdata;
  logic        stat_rd, in_hs, out_hs;
  logic        eng_tap_req, lite_tap_rd_req, lite_tap_wr_req;
  logic        ap_start, ap_done, ap_idle;
  logic [31:0] data_length;
  logic        ss_gate, sm_tlast, eng_tap_gnt, lite_tap_gnt, proto_err;

  int checks = 0;
  int errors = 0;

  always #5 axis_clk = ~axis_clk;

  fir_ap_ctrl #(.pDATA_WIDTH(32), .LEN_WIDTH(32)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .cfg_wr(cfg_wr), .cfg_wdata(cfg_wdata),
    .len_wr(len_wr), .len_wdata(len_wdata),
    .stat_rd(stat_rd), .in_hs(in_hs), .out_hs(out_hs),
    .eng_tap_req(eng_tap_req), .lite_tap_rd_req(lite_tap_rd_req),
    .lite_tap_wr_req(lite_tap_wr_req),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .data_length(data_length), .ss_gate(ss_gate), .sm_tlast(sm_tlast),
    .eng_tap_gnt(eng_tap_gnt), .lite_tap_gnt(lite_tap_gnt),
    .proto_err(proto_err)
  );

  // Inputs, then expectations before the edge (grants, decodes) and after it.
  typedef struct {
    logic cw, cd, lw; logic [31:0] ld;
    logic sr, ih, oh, er, rr, wr;
    logic e_eg, e_lg, e_tl, e_sg;
    logic e_st, e_dn, e_id; logic [31:0] e_len; logic e_pe;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    cfg_wr = 0; cfg_wdata = '0; len_wr = 0; len_wdata = '0; stat_rd = 0;
    in_hs = 0; out_hs = 0; eng_tap_req = 0; lite_tap_rd_req = 0; lite_tap_wr_req = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge axis_clk);
    cfg_wr = v.cw; cfg_wdata = {31'd0, v.cd}; len_wr = v.lw; len_wdata = v.ld;
    stat_rd = v.sr; in_hs = v.ih; out_hs = v.oh;
    eng_tap_req = v.er; lite_tap_rd_req = v.rr; lite_tap_wr_req = v.wr;
    #1;
    chk("eng_tap_gnt", idx, 32'(eng_tap_gnt), 32'(v.e_eg));
    chk("lite_tap_gnt", idx, 32'(lite_tap_gnt), 32'(v.e_lg));
    chk("sm_tlast", idx, 32'(sm_tlast), 32'(v.e_tl));
    chk("ss_gate", idx, 32'(ss_gate), 32'(v.e_sg));
    if (eng_tap_gnt && lite_tap_gnt) chk("grant_overlap", idx, 32'd1, 32'd0);
    @(posedge axis_clk); #1;
    chk("ap_start", idx, 32'(ap_start), 32'(v.e_st));
    chk("ap_done", idx, 32'(ap_done), 32'(v.e_dn));
    chk("ap_idle", idx, 32'(ap_idle), 32'(v.e_id));
    chk("data_length", idx, data_length, v.e_len);
    chk("proto_err", idx, 32'(proto_err), 32'(v.e_pe));
  endtask

  initial begin
    //            cw cd lw ld  sr ih oh er rr wr | eg lg tl sg | st dn id len pe
    vecs[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 1, 0,   0, 1, 0, 0,   0, 0, 1, 0, 0}; // start with len 0 ignored
    vecs[1]  = '{0, 0, 1, 3,  0, 0, 0, 0, 0, 1,   0, 1, 0, 0,   0, 0, 1, 3, 0}; // idle lite write granted
    vecs[2]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   1, 0, 0, 3, 0}; // start -> ARMED
    vecs[3]  = '{0, 0, 1, 7,  0, 0, 0, 1, 1, 1,   1, 0, 0, 1,   1, 0, 0, 3, 0}; // len_wr ignored, eng wins
    vecs[4]  = '{0, 0, 0, 0,  0, 1, 0, 0, 1, 1,   0, 1, 0, 1,   0, 0, 0, 3, 0}; // first in -> RUN
    vecs[5]  = '{1, 1, 0, 0,  0, 1, 0, 1, 0, 0,   1, 0, 0, 1,   0, 0, 0, 3, 0}; // re-start ignored
    vecs[6]  = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0,   0, 0, 0, 1,   0, 0, 0, 3, 0}; // last in + first out
    vecs[7]  = '{0, 0, 0, 0,  0, 0, 1, 0, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3, 0}; // DRAIN, wr held off
    vecs[8]  = '{0, 0, 0, 0,  0, 0, 1, 0, 1, 0,   0, 1, 1, 0,   0, 1, 1, 3, 0}; // last out, tlast
    vecs[9]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 1, 1, 3, 0}; // done holds
    vecs[10] = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 3, 0}; // stat_rd clears
    vecs[11] = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 1, 0}; // len 1
    vecs[12] = '{1, 1, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   1, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 0,   0, 0, 0, 1,   0, 0, 0, 1, 0}; // ARMED -> DRAIN
    vecs[14] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 0,   0, 0, 0, 1, 0}; // tlast on first out
    vecs[15] = '{0, 0, 0, 0,  1, 0, 1, 0, 0, 0,   0, 0, 1, 0,   0, 1, 1, 1, 0}; // set beats stat_rd
    vecs[16] = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 1, 0};
    vecs[17] = '{0, 0, 1, 2,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2, 0}; // len 2
    vecs[18] = '{1, 1, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   1, 0, 0, 2, 0};
    vecs[19] = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 0,   0, 0, 0, 1,   0, 0, 0, 2, 0};
    vecs[20] = '{0, 0, 0, 0,  0, 0, 1, 0, 0, 0,   0, 0, 0, 1,   0, 0, 0, 2, 0};
    vecs[21] = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0,   0, 0, 1, 1,   0, 1, 1, 2, 0}; // RUN -> IDLE direct
    vecs[22] = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2, 0}; // gate low: not DRAIN
    vecs[23] = '{0, 0, 0, 0,  0, 0, 1, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2, 1}; // out in IDLE
    vecs[24] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1, 2, 1}; // sticky

    drive_idle();
    axis_rst = 1'b1;
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    chk("rst_ap_idle", -1, 32'(ap_idle), 32'd1);
    chk("rst_ap_done", -1, 32'(ap_done), 32'd0);
    chk("rst_ap_start", -1, 32'(ap_start), 32'd0);
    chk("rst_ss_gate", -1, 32'(ss_gate), 32'd0);
    chk("rst_proto_err", -1, 32'(proto_err), 32'd0);
    chk("rst_data_length", -1, data_length, 32'd0);

    for (int i = 0; i < 25; i++) apply(vecs[i], i);

    // Reset asserted mid-run with handshakes present in that cycle.
    @(negedge axis_clk); drive_idle(); cfg_wr = 1; cfg_wdata = 32'd1;
    @(negedge axis_clk); drive_idle(); in_hs = 1;
    @(negedge axis_clk); drive_idle(); #1;
    chk("midrun_ss_gate", 100, 32'(ss_gate), 32'd1);
    axis_rst = 1; in_hs = 1; out_hs = 1; eng_tap_req = 1; lite_tap_rd_req = 1;
    @(posedge axis_clk); #1;
    chk("rst_run_ap_idle", 101, 32'(ap_idle), 32'd1);
    chk("rst_run_ap_start", 101, 32'(ap_start), 32'd0);
    chk("rst_run_ap_done", 101, 32'(ap_done), 32'd0);
    chk("rst_run_data_length", 101, data_length, 32'd0);
    chk("rst_run_ss_gate", 101, 32'(ss_gate), 32'd0);
    chk("rst_run_sm_tlast", 101, 32'(sm_tlast), 32'd0);
    chk("rst_run_proto_err", 101, 32'(proto_err), 32'd0);
    chk("rst_run_eng_gnt", 101, 32'(eng_tap_gnt), 32'd0);
    chk("rst_run_lite_gnt", 101, 32'(lite_tap_gnt), 32'd1);
    @(negedge axis_clk); drive_idle(); axis_rst = 0;
    // After reset, a start with the cleared length must be ignored.
    cfg_wr = 1; cfg_wdata = 32'd1;
    @(posedge axis_clk); #1;
    chk("post_rst_start_ignored", 102, 32'(ap_idle), 32'd1);
    @(negedge axis_clk); drive_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
